ring_sequence_monitor: RTL

// - Receive side of the one-hot ring counter: samples the NBITS_COUNT-bit ring word, decodes it to a binary index,

---
 rtl/ring_pkg.sv | 28 ++
 rtl/onehot_classify.sv | 27 ++
 rtl/ring_sequence_monitor.sv | 134 +++++++++++++
 3 files changed

// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring receive side.
// Holds the default ring width, FSM/classification enums and the ring rotate.
package ring_pkg;

    localparam int NBITS_COUNT_DEFAULT = 4;
    localparam int RING_MAX            = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } ring_state_e;

    typedef enum logic [1:0] {
        ZERO   = 2'd0,
        ONEHOT = 2'd1,
        MULTI  = 2'd2
    } ring_class_e;

    // Rotate the low n bits of w left by one; bits at n and above come back as 0.
    function automatic logic [RING_MAX-1:0] rotl(input logic [RING_MAX-1:0] w,
                                                  input int unsigned        n);
        logic [RING_MAX-1:0] mask;
        mask = ~({RING_MAX{1'b1}} << n);
        return ((w << 1) | (w >> (n - 1))) & mask;
    endfunction

endpackage

// File: rtl/onehot_classify.sv
// Combinational classifier for a ring word: zero / one-hot / multi-bit,
// plus the binary position of the highest set bit.
module onehot_classify
    import ring_pkg::*;
#(
    parameter  int NBITS_COUNT = NBITS_COUNT_DEFAULT,
    localparam int IDX_W       = $clog2(NBITS_COUNT)
) (
    input  logic [NBITS_COUNT-1:0] ring_in,
    output ring_class_e            cls,
    output logic [IDX_W-1:0]       pos
);

    always_comb begin
        pos = '0;
        for (int i = 0; i < NBITS_COUNT; i++) begin
            if (ring_in[i]) pos = IDX_W'(i);
        end
    end

    always_comb begin
        if (ring_in == '0)        cls = ZERO;
        else if ($onehot(ring_in)) cls = ONEHOT;
        else                       cls = MULTI;
    end

endmodule

// File: rtl/ring_sequence_monitor.sv
// Receive-side monitor for the one-hot ring counter: decodes the ring word,
// checks each accepted step against rotate-left, counts laps and fault entries.
module ring_sequence_monitor
    import ring_pkg::*;
#(
    parameter  int NBITS_COUNT = NBITS_COUNT_DEFAULT,   // must be 2..RING_MAX
    parameter  int LAP_W       = 8,
    parameter  int ERR_W       = 4,
    localparam int IDX_W       = $clog2(NBITS_COUNT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_en,
    input  logic [NBITS_COUNT-1:0] ring_in,
    input  logic                   clear_stats,
    output logic [IDX_W-1:0]       index,
    output logic                   index_valid,
    output logic                   lap_done,
    output logic                   resync,
    output logic                   step_error,
    output logic [LAP_W-1:0]       lap_count,
    output logic [ERR_W-1:0]       err_count
);

    localparam logic [NBITS_COUNT-1:0] RING_ONE = NBITS_COUNT'(1);
    localparam logic [ERR_W-1:0]       ERR_MAX  = {ERR_W{1'b1}};

    ring_state_e            state_q, state_d;
    logic [NBITS_COUNT-1:0] last_q, last_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [LAP_W-1:0]       lap_q, lap_d;
    logic [ERR_W-1:0]       err_q, err_d;
    logic                   lap_pulse_q, lap_pulse_d;
    logic                   resync_q, resync_d;
    logic                   step_err_q, step_err_d;

    ring_class_e            cls;
    logic [IDX_W-1:0]       pos;
    logic [NBITS_COUNT-1:0] expected;
    logic                   match;
    logic                   is_one;

    onehot_classify #(.NBITS_COUNT(NBITS_COUNT)) u_classify (
        .ring_in (ring_in),
        .cls     (cls),
        .pos     (pos)
    );

    assign expected = NBITS_COUNT'(rotl(RING_MAX'(last_q), NBITS_COUNT));
    assign match    = (ring_in == expected);
    assign is_one   = (ring_in == RING_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= '0;
            index_q     <= '0;
            lap_q       <= '0;
            err_q       <= '0;
            lap_pulse_q <= 1'b0;
            resync_q    <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            index_q     <= index_d;
            lap_q       <= lap_d;
            err_q       <= err_d;
            lap_pulse_q <= lap_pulse_d;
            resync_q    <= resync_d;
            step_err_q  <= step_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (cls == ONEHOT)     state_d = TRACK;
                    else if (cls == MULTI) state_d = FAULT;
                end
                TRACK: begin
                    if (match || is_one)  state_d = TRACK;
                    else if (cls == ZERO) state_d = IDLE;
                    else                  state_d = FAULT;
                end
                FAULT: begin
                    if (is_one)           state_d = TRACK;
                    else if (cls == ZERO) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Index/expected only advance on entry to or within TRACK; IDLE and FAULT keep the last legal index.
    always_comb begin
        last_d      = last_q;
        index_d     = index_q;
        lap_d       = lap_q;
        err_d       = err_q;
        lap_pulse_d = 1'b0;
        resync_d    = 1'b0;
        step_err_d  = 1'b0;
        if (sample_en) begin
            if (state_d == TRACK) begin
                last_d  = ring_in;
                index_d = pos;
                if (state_q == TRACK && match && pos == '0) begin
                    lap_pulse_d = 1'b1;
                    lap_d       = lap_q + LAP_W'(1);
                end
                if (state_q == TRACK && !match && is_one) resync_d = 1'b1;
            end else if (state_d == FAULT && state_q != FAULT) begin
                step_err_d = 1'b1;
                if (err_q != ERR_MAX) err_d = err_q + ERR_W'(1);
            end
        end
        if (clear_stats) begin
            lap_d = '0;
            err_d = '0;
        end
    end

    assign index       = index_q;
    assign index_valid = (state_q == TRACK);
    assign lap_done    = lap_pulse_q;
    assign resync      = resync_q;
    assign step_error  = step_err_q;
    assign lap_count   = lap_q;
    assign err_count   = err_q;

endmodule
